bsg_dll_lock_ctrl: RTL and testbench

Closed-loop lock controller for the DLL oscillator. It drives the oscillator's drive-strength (ds) and tap-control (ctl) settings and requests frequency measurements from the clock monitor. A 4-bit successive-approximation search brings the monitor count onto a programmed target, then tracks drift with ±1 code steps and reports lock. It sits between the bsg_tag-configured target and the oscillator/monitor, replacing manual tag-driven tuning.

---
 rtl/bsg_chip_pkg.sv | 29 ++
 rtl/bsg_dll_lock_timer.sv | 29 ++
 rtl/bsg_dll_lock_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bsg_dll_lock_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_chip_pkg.sv
// Shared chip-level widths and types for the DLL
// oscillator and its closed-loop lock controller.
package bsg_chip_pkg;

  localparam int osc_ds_width_gp    = 2;
  localparam int osc_ctl_width_gp   = 2;
  localparam int osc_code_width_gp  =
    osc_ds_width_gp + osc_ctl_width_gp;
  localparam int div_count_width_gp = 8;

  typedef enum logic [2:0] {
    e_dll_idle,
    e_dll_apply,
    e_dll_settle,
    e_dll_meas,
    e_dll_decide,
    e_dll_track_wait
  } bsg_dll_lock_state_e;

  typedef enum logic {
    e_dll_sar,
    e_dll_track
  } bsg_dll_lock_phase_e;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_dll_lock_timer.sv
// Loadable down-counter shared by the settle and
// tracking-interval waits of the DLL lock controller.
module bsg_dll_lock_timer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_r;

  // High on the cycle whose decrement brings the count to zero
  assign zero_o = (cnt_r <= width_p'(1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (dec_i && (cnt_r != '0)) begin
      cnt_r <= cnt_r - width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_dll_lock_ctrl.sv
// DLL lock controller: 4-bit SAR search of the oscillator
// code onto a target count, then +/-1 drift tracking.
module bsg_dll_lock_ctrl
  import bsg_chip_pkg::*;
#(
  parameter int count_width_p    = div_count_width_gp,
  parameter int settle_cycles_p  = 16,
  parameter int track_interval_p = 64,
  parameter int tol_p            = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        en_i,
  input  logic [count_width_p-1:0]    target_i,
  output logic                        meas_req_o,
  input  logic                        meas_v_i,
  input  logic [count_width_p-1:0]    meas_count_i,
  output logic [osc_ds_width_gp-1:0]  osc_ds_o,
  output logic [osc_ctl_width_gp-1:0] osc_ctl_o,
  output logic                        osc_trigger_o,
  output logic                        lock_o,
  output logic                        sat_o
);

  localparam int tmr_width_lp =
    $clog2(max_int(settle_cycles_p, track_interval_p)) + 1;
  localparam int cw1_lp = count_width_p + 1;
  localparam int bit_width_lp = $clog2(osc_code_width_gp);
  localparam logic [cw1_lp-1:0] tol_lp = cw1_lp'(tol_p);

  typedef logic [osc_code_width_gp-1:0] code_t;
  typedef logic [bit_width_lp-1:0] bit_t;

  bsg_dll_lock_state_e state_r, state_n;
  bsg_dll_lock_phase_e phase_r, phase_n;
  code_t code_r, code_n;
  bit_t bit_r, bit_n;
  logic [count_width_p-1:0] count_r, count_n;
  logic lock_r, lock_n;
  logic sat_r, sat_n;

  logic tmr_load, tmr_dec, tmr_zero;
  logic [tmr_width_lp-1:0] tmr_val;
  logic fast, slow;

  bsg_dll_lock_timer #(
    .width_p(tmr_width_lp)
  ) timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  // One extra bit so target+tol and count+tol never wrap
  assign fast = {1'b0, count_r} > ({1'b0, target_i} + tol_lp);
  assign slow = ({1'b0, count_r} + tol_lp) < {1'b0, target_i};

  always_comb begin
    state_n  = state_r;
    phase_n  = phase_r;
    code_n   = code_r;
    bit_n    = bit_r;
    count_n  = count_r;
    sat_n    = sat_r;
    lock_n   = (phase_r == e_dll_track) ? lock_r : 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = tmr_width_lp'(settle_cycles_p);
    if (!en_i) begin
      state_n = e_dll_idle;
      lock_n  = 1'b0;
    end else begin
      unique case (state_r)
        e_dll_idle: begin
          code_n  = code_t'(1) << (osc_code_width_gp - 1);
          bit_n   = bit_t'(osc_code_width_gp - 1);
          phase_n = e_dll_sar;
          sat_n   = 1'b0;
          lock_n  = 1'b0;
          state_n = e_dll_apply;
        end
        e_dll_apply: begin
          tmr_load = 1'b1;
          state_n  = e_dll_settle;
        end
        e_dll_settle: begin
          tmr_dec = 1'b1;
          if (tmr_zero) state_n = e_dll_meas;
        end
        e_dll_meas: begin
          if (meas_v_i) begin
            count_n = meas_count_i;
            state_n = e_dll_decide;
          end
        end
        e_dll_decide: begin
          if (phase_r == e_dll_sar) begin
            if (count_r < target_i) code_n[bit_r] = 1'b0;
            if (bit_r != '0) begin
              code_n[bit_r - bit_t'(1)] = 1'b1;
              bit_n   = bit_r - bit_t'(1);
              state_n = e_dll_apply;
            end else begin
              phase_n  = e_dll_track;
              state_n  = e_dll_track_wait;
              tmr_load = 1'b1;
              tmr_val  = tmr_width_lp'(track_interval_p);
            end
          end else begin
            lock_n   = !(fast || slow);
            state_n  = e_dll_track_wait;
            tmr_load = 1'b1;
            tmr_val  = tmr_width_lp'(track_interval_p);
            if (fast) begin
              if (code_r != '1) begin
                code_n   = code_r + code_t'(1);
                state_n  = e_dll_apply;
                tmr_load = 1'b0;
              end else begin
                sat_n = 1'b1;
              end
            end else if (slow) begin
              if (code_r != '0) begin
                code_n   = code_r - code_t'(1);
                state_n  = e_dll_apply;
                tmr_load = 1'b0;
              end else begin
                sat_n = 1'b1;
              end
            end
          end
        end
        e_dll_track_wait: begin
          tmr_dec = 1'b1;
          if (tmr_zero) state_n = e_dll_meas;
        end
        default: state_n = e_dll_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_dll_idle;
      phase_r <= e_dll_sar;
      code_r  <= '0;
      bit_r   <= '0;
      count_r <= '0;
      lock_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      phase_r <= phase_n;
      code_r  <= code_n;
      bit_r   <= bit_n;
      count_r <= count_n;
      lock_r  <= lock_n;
      sat_r   <= sat_n;
    end
  end

  assign {osc_ds_o, osc_ctl_o} = code_r;
  assign meas_req_o    = (state_r == e_dll_meas);
  assign osc_trigger_o = (state_r == e_dll_apply);
  assign lock_o        = lock_r;
  assign sat_o         = sat_r;

endmodule

// File: tb/tb_bsg_dll_lock_ctrl.sv
// Directed bench for bsg_dll_lock_ctrl with an oscillator
// model: count = base - 10*code, answered 5 cycles later.
module tb_bsg_dll_lock_ctrl;
  import bsg_chip_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       en_i;
  logic [7:0] target_i;
  logic       meas_req_o;
  logic       meas_v_i;
  logic [7:0] meas_count_i;
  logic [1:0] osc_ds_o;
  logic [1:0] osc_ctl_o;
  logic       osc_trigger_o;
  logic       lock_o;
  logic       sat_o;

  bsg_dll_lock_ctrl #(
    .count_width_p   (8),
    .settle_cycles_p (4),
    .track_interval_p(8),
    .tol_p           (2)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .en_i         (en_i),
    .target_i     (target_i),
    .meas_req_o   (meas_req_o),
    .meas_v_i     (meas_v_i),
    .meas_count_i (meas_count_i),
    .osc_ds_o     (osc_ds_o),
    .osc_ctl_o    (osc_ctl_o),
    .osc_trigger_o(osc_trigger_o),
    .lock_o       (lock_o),
    .sat_o        (sat_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Oscillator / monitor model
  logic       model_en = 1'b0;
  logic       model_v  = 1'b0;
  logic [7:0] model_cnt = '0;
  logic       inj_v = 1'b0;
  logic [7:0] inj_cnt = '0;
  int         base = 200;
  int         pend = 0;
  bit         busy = 0;

  assign meas_v_i     = model_v | inj_v;
  assign meas_count_i = inj_v ? inj_cnt : model_cnt;

  initial begin
    forever begin
      @(negedge clk_i);
      model_v = 1'b0;
      if (!model_en) begin
        pend = 0;
        busy = 0;
      end else if (busy) begin
        if (!meas_req_o) busy = 0;
        else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            model_v   = 1'b1;
            model_cnt = 8'(base - 10 * int'({osc_ds_o, osc_ctl_o}));
          end
        end
      end else if (meas_req_o) begin
        busy = 1;
        pend = 5;
      end
    end
  end

  // Trigger log
  logic [3:0] trig_q[$];
  int  wid_err = 0;
  bit  prev_trig = 0;

  always @(negedge clk_i) begin
    if (osc_trigger_o) begin
      trig_q.push_back({osc_ds_o, osc_ctl_o});
      if (prev_trig) wid_err++;
    end
    prev_trig = osc_trigger_o;
  end

  function automatic int trig_at(input int idx);
    if (idx < trig_q.size()) return int'(trig_q[idx]);
    return 99;
  endfunction

  function automatic int code_now();
    return int'({osc_ds_o, osc_ctl_o});
  endfunction

  typedef struct {
    int base;
    int target;
    int fcode;
    int ntrig;
    int lock;
    int sat;
    int t0, t1, t2, t3;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    en_i      = 1'b0;
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  int tb;

  initial begin
    vecs[0] = '{200, 150,  5, 4, 1, 0, 8,  4,  6,  5};
    vecs[1] = '{200, 250,  0, 4, 0, 1, 8,  4,  2,  1};
    vecs[2] = '{200, 100, 10, 4, 1, 0, 8, 12, 10, 11};
    vecs[3] = '{200,  50, 15, 4, 1, 0, 8, 12, 14, 15};
    vecs[4] = '{200,   0, 15, 4, 0, 1, 8, 12, 14, 15};
    vecs[5] = '{200, 152,  5, 5, 1, 0, 8,  4,  6,  5};

    en_i      = 1'b0;
    target_i  = 8'd150;
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst code", code_now(), 0);
    chk("rst req", int'(meas_req_o), 0);
    chk("rst trig", int'(osc_trigger_o), 0);
    chk("rst lock", int'(lock_o), 0);
    chk("rst sat", int'(sat_o), 0);
    chk("rst state", int'(dut.state_r), int'(e_dll_idle));
    model_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      base     = vecs[i].base;
      target_i = 8'(vecs[i].target);
      tb       = trig_q.size();
      en_i     = 1'b1;
      repeat (200) @(negedge clk_i);
      chk($sformatf("v%0d code", i), code_now(), vecs[i].fcode);
      chk($sformatf("v%0d lock", i), int'(lock_o), vecs[i].lock);
      chk($sformatf("v%0d sat", i), int'(sat_o), vecs[i].sat);
      chk($sformatf("v%0d ntrig", i), trig_q.size() - tb,
          vecs[i].ntrig);
      chk($sformatf("v%0d t0", i), trig_at(tb), vecs[i].t0);
      chk($sformatf("v%0d t1", i), trig_at(tb + 1), vecs[i].t1);
      chk($sformatf("v%0d t2", i), trig_at(tb + 2), vecs[i].t2);
      chk($sformatf("v%0d t3", i), trig_at(tb + 3), vecs[i].t3);
      chk($sformatf("v%0d width", i), wid_err, 0);
    end

    // Drift after lock
    do_reset();
    base = 200;
    target_i = 8'd150;
    en_i = 1'b1;
    for (int k = 0; k < 300 && !lock_o; k++) @(negedge clk_i);
    chk("drift lock0", int'(lock_o), 1);
    chk("drift code0", code_now(), 5);
    tb = trig_q.size();
    base = 210;
    for (int k = 0; k < 200 && lock_o; k++) @(negedge clk_i);
    chk("drift unlock", int'(lock_o), 0);
    chk("drift step", code_now(), 6);
    for (int k = 0; k < 200 && !lock_o; k++) @(negedge clk_i);
    chk("drift relock", int'(lock_o), 1);
    chk("drift code1", code_now(), 6);
    chk("drift ntrig", trig_q.size() - tb, 1);
    chk("drift tcode", trig_at(tb), 6);

    // Spurious pulse in TRACK_WAIT
    for (int k = 0; k < 50 && dut.state_r != e_dll_track_wait; k++)
      @(negedge clk_i);
    inj_cnt = 8'd0;
    inj_v = 1'b1;
    @(negedge clk_i);
    inj_v = 1'b0;
    chk("spur tw state", int'(dut.state_r), int'(e_dll_track_wait));
    chk("spur tw code", code_now(), 6);
    chk("spur tw lock", int'(lock_o), 1);

    // Spurious pulse in SETTLE
    do_reset();
    base = 200;
    en_i = 1'b1;
    for (int k = 0; k < 20 && !osc_trigger_o; k++) @(negedge clk_i);
    chk("spur st trig", int'(osc_trigger_o), 1);
    @(negedge clk_i);
    inj_cnt = 8'd255;
    inj_v = 1'b1;
    @(negedge clk_i);
    inj_v = 1'b0;
    chk("spur st state", int'(dut.state_r), int'(e_dll_settle));
    chk("spur st code", code_now(), 8);
    for (int k = 0; k < 300 && !lock_o; k++) @(negedge clk_i);
    chk("spur st final", code_now(), 5);

    // Abort in MEAS of the second SAR step
    do_reset();
    tb = trig_q.size();
    en_i = 1'b1;
    for (int k = 0; k < 100 && trig_q.size() - tb < 2; k++)
      @(negedge clk_i);
    for (int k = 0; k < 50 && !meas_req_o; k++) @(negedge clk_i);
    chk("abort in meas", int'(meas_req_o), 1);
    model_en = 1'b0;
    en_i = 1'b0;
    @(negedge clk_i);
    chk("abort state", int'(dut.state_r), int'(e_dll_idle));
    chk("abort req", int'(meas_req_o), 0);
    chk("abort lock", int'(lock_o), 0);
    chk("abort trig", int'(osc_trigger_o), 0);
    inj_cnt = 8'd200;
    inj_v = 1'b1;
    @(negedge clk_i);
    inj_v = 1'b0;
    @(negedge clk_i);
    chk("late v state", int'(dut.state_r), int'(e_dll_idle));
    chk("late v code", code_now(), 4);
    chk("late v ntrig", trig_q.size() - tb, 2);
    model_en = 1'b1;
    tb = trig_q.size();
    en_i = 1'b1;
    for (int k = 0; k < 10 && trig_q.size() == tb; k++)
      @(negedge clk_i);
    chk("restart code", trig_at(tb), 8);

    // Async reset mid-SETTLE
    for (int k = 0; k < 50 && dut.state_r != e_dll_settle; k++)
      @(negedge clk_i);
    chk("ar in settle", int'(dut.state_r), int'(e_dll_settle));
    #1 reset_n_i = 1'b0;
    #1;
    chk("ar code", code_now(), 0);
    chk("ar req", int'(meas_req_o), 0);
    chk("ar trig", int'(osc_trigger_o), 0);
    chk("ar lock", int'(lock_o), 0);
    chk("ar sat", int'(sat_o), 0);
    @(negedge clk_i);
    en_i = 1'b0;
    reset_n_i = 1'b1;
    tb = trig_q.size();
    repeat (10) @(negedge clk_i);
    chk("ar idle", int'(dut.state_r), int'(e_dll_idle));
    chk("ar no trig", trig_q.size() - tb, 0);

    // sat_o is sticky until the next start
    target_i = 8'd250;
    en_i = 1'b1;
    for (int k = 0; k < 300 && !sat_o; k++) @(negedge clk_i);
    chk("sat set", int'(sat_o), 1);
    en_i = 1'b0;
    @(negedge clk_i);
    chk("sat held", int'(sat_o), 1);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("sat clr", int'(sat_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
